// File: rtl/bupdate_gen_pkg.sv
// Shared control-packet definitions: tags, ethertype, message codes and the
// update generator's state encoding.
package bupdate_gen_pkg;

    localparam logic [47:0] CTRL_MAC   = 48'h0;
    localparam logic [15:0] ETH_TYPE   = 16'h1662;
    localparam logic [7:0]  MSG_REPORT = 8'h01;
    localparam logic [7:0]  MSG_UPDATE = 8'h02;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_MID  = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_W0   = 3'd1;
    localparam logic [2:0] ST_W1   = 3'd2;
    localparam logic [2:0] ST_W2   = 3'd3;
    localparam logic [2:0] ST_W3   = 3'd4;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic        direction;
        logic [31:0] token_bucket_para;
        logic [47:0] direct_mac_addr;
        logic [31:0] time_slot_period;
        logic [47:0] ptime;
    } upd_req_t;

    // Packets are always 64 B, so the invalid-byte count is fixed at zero.
    function automatic logic [133:0] pkt_word(input logic [1:0] tag, input logic [127:0] payload);
        return {tag, 4'h0, payload};
    endfunction

endpackage

// File: rtl/bupdate_gen_if.sv
// Request and packet-bus signals of the beacon update generator.
interface bupdate_gen_if;

    logic         req_valid;
    logic         req_ready;
    logic [47:0]  req_dst_mac;
    logic         req_direction;
    logic [31:0]  req_token_bucket_para;
    logic [47:0]  req_direct_mac_addr;
    logic [31:0]  req_time_slot_period;
    logic [47:0]  precision_time;
    logic         out_ready;
    logic [133:0] out_data;
    logic         out_data_wr;
    logic         out_data_valid;
    logic         out_data_valid_wr;
    logic [7:0]   seq_num;
    logic [63:0]  sent_cnt;

    modport master (
        input  req_valid, req_dst_mac, req_direction, req_token_bucket_para,
               req_direct_mac_addr, req_time_slot_period, precision_time, out_ready,
        output req_ready, out_data, out_data_wr, out_data_valid, out_data_valid_wr,
               seq_num, sent_cnt
    );

    modport slave (
        output req_valid, req_dst_mac, req_direction, req_token_bucket_para,
               req_direct_mac_addr, req_time_slot_period, precision_time, out_ready,
        input  req_ready, out_data, out_data_wr, out_data_valid, out_data_valid_wr,
               seq_num, sent_cnt
    );

endinterface

// File: rtl/bupdate_gen.sv
// Beacon update generator: turns one register-write request into a 4-word
// update packet on the 134-bit packet bus, with sequence and sent counters.
module bupdate_gen
    import bupdate_gen_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    bupdate_gen_if.master bus
);

    logic [2:0]   state_q, state_d;
    upd_req_t     req_q, req_d;
    logic [7:0]   seq_q, seq_d;
    logic [63:0]  cnt_q, cnt_d;
    logic [133:0] data_q, data_d;
    logic         wr_q, wr_d;
    logic         vld_q, vld_d;
    logic         accept;

    assign bus.req_ready = (state_q == ST_IDLE) && bus.out_ready;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_W0;
                    req_d   = '{dst_mac:           bus.req_dst_mac,
                                direction:         bus.req_direction,
                                token_bucket_para: bus.req_token_bucket_para,
                                direct_mac_addr:   bus.req_direct_mac_addr,
                                time_slot_period:  bus.req_time_slot_period,
                                ptime:             bus.precision_time};
                end
            end
            ST_W0: state_d = ST_W1;
            ST_W1: state_d = ST_W2;
            ST_W2: state_d = ST_W3;
            ST_W3: begin
                state_d = ST_IDLE;
                seq_d   = seq_q + 8'd1;
                cnt_d   = cnt_q + 64'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so each word is built from the state being entered.
    always_comb begin
        data_d = data_q;
        wr_d   = 1'b1;
        vld_d  = 1'b0;
        case (state_d)
            ST_W0: data_d = pkt_word(TAG_HEAD, {req_d.dst_mac, CTRL_MAC, ETH_TYPE,
                                                MSG_UPDATE, seq_q});
            ST_W1: data_d = pkt_word(TAG_MID, {req_d.ptime, req_d.direction, 15'h0,
                                               req_d.token_bucket_para,
                                               req_d.time_slot_period});
            ST_W2: data_d = pkt_word(TAG_MID, {req_d.direct_mac_addr, 80'h0});
            ST_W3: begin
                data_d = pkt_word(TAG_TAIL, 128'h0);
                vld_d  = 1'b1;
            end
            default: wr_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            seq_q   <= 8'h0;
            cnt_q   <= 64'h0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.out_data          = data_q;
    assign bus.out_data_wr       = wr_q;
    assign bus.out_data_valid    = vld_q;
    assign bus.out_data_valid_wr = vld_q;
    assign bus.seq_num           = seq_q;
    assign bus.sent_cnt          = cnt_q;

endmodule

// File: tb/tb_bupdate_gen.sv
// Directed bench for bupdate_gen: packet-level model checked every cycle plus
// hand-computed literal expectations.
module tb_bupdate_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bupdate_gen_if bus ();

    bupdate_gen u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Hand-computed words for the first directed packet.
    localparam logic [133:0] W0 = {2'b01, 4'h0, 48'h0000_0000_0001, 48'h0, 16'h1662,
                                   8'h02, 8'h00};
    localparam logic [133:0] W1 = {2'b11, 4'h0, 48'h0000_1234_5678, 1'b1, 15'h0,
                                   32'h0000_1000, 32'h0000_7A12};
    localparam logic [133:0] W2 = {2'b11, 4'h0, 48'hAABB_CCDD_EEFF, 80'h0};
    localparam logic [133:0] W3 = {2'b10, 132'h0};

    // Packet-level model: a queue of words still to emit for the accepted packet.
    logic [133:0] m_q[$];
    logic [7:0]   m_seq = 8'h0;
    logic [63:0]  m_cnt = 64'h0;
    logic [133:0] e_data = '0;
    logic         e_wr = 1'b0;
    logic         e_vld = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_seq  = 8'h0;
            m_cnt  = 64'h0;
            e_data = '0;
            e_wr   = 1'b0;
            e_vld  = 1'b0;
        end
        chk("m_out_data", bus.out_data, e_data);
        chk("m_out_data_wr", bus.out_data_wr, e_wr);
        chk("m_out_data_valid", bus.out_data_valid, e_vld);
        chk("m_out_data_valid_wr", bus.out_data_valid_wr, e_vld);
        chk("m_seq_num", bus.seq_num, m_seq);
        chk("m_sent_cnt", bus.sent_cnt, m_cnt);
        chk("m_req_ready", bus.req_ready, (m_q.size() == 0) && !e_wr && bus.out_ready);
        if (rst_n) begin
            if (e_vld) begin
                m_seq = m_seq + 8'd1;
                m_cnt = m_cnt + 64'd1;
            end
            if (m_q.size() == 0 && !e_wr && bus.out_ready && bus.req_valid) begin
                m_q.push_back({2'b01, 4'h0, bus.req_dst_mac, 48'h0, 16'h1662, 8'h02, m_seq});
                m_q.push_back({2'b11, 4'h0, bus.precision_time, bus.req_direction, 15'h0,
                               bus.req_token_bucket_para, bus.req_time_slot_period});
                m_q.push_back({2'b11, 4'h0, bus.req_direct_mac_addr, 80'h0});
                m_q.push_back({2'b10, 132'h0});
            end
            if (m_q.size() > 0) begin
                e_data = m_q.pop_front();
                e_wr   = 1'b1;
                e_vld  = (m_q.size() == 0);
            end else begin
                e_wr  = 1'b0;
                e_vld = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [47:0] dst, input logic dir, input logic [31:0] tok,
                           input logic [47:0] dmac, input logic [31:0] per,
                           input logic [47:0] pt);
        bus.req_dst_mac           = dst;
        bus.req_direction         = dir;
        bus.req_token_bucket_para = tok;
        bus.req_direct_mac_addr   = dmac;
        bus.req_time_slot_period  = per;
        bus.precision_time        = pt;
    endtask

    int         hc[3];
    logic [7:0] hs[3];
    int         nheads;
    logic [7:0] last_seq;

    initial begin
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_req(48'h0, 1'b0, 32'h0, 48'h0, 32'h0, 48'h0);

        // Reset state
        tick(); tick(); tick();
        @(negedge clk);
        chk("rst_out_data", bus.out_data, 134'h0);
        chk("rst_out_data_wr", bus.out_data_wr, 1'b0);
        chk("rst_seq_num", bus.seq_num, 8'h00);
        chk("rst_sent_cnt", bus.sent_cnt, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single request with exact field positions
        bus.out_ready = 1'b1;
        set_req(48'h0000_0000_0001, 1'b1, 32'h0000_1000, 48'hAABB_CCDD_EEFF, 32'h7A12,
                48'h0000_1234_5678);
        bus.req_valid = 1'b1;
        @(negedge clk);
        chk("t1_req_ready", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("t1_word0", bus.out_data, W0);
        chk("t1_wr0", bus.out_data_wr, 1'b1);
        chk("t1_vwr0", bus.out_data_valid_wr, 1'b0);
        chk("t1_ready_busy", bus.req_ready, 1'b0);
        tick();
        @(negedge clk);
        chk("t1_word1", bus.out_data, W1);
        tick();
        @(negedge clk);
        chk("t1_word2", bus.out_data, W2);
        chk("t1_vwr2", bus.out_data_valid_wr, 1'b0);
        tick();
        @(negedge clk);
        chk("t1_word3", bus.out_data, W3);
        chk("t1_vwr3", bus.out_data_valid_wr, 1'b1);
        chk("t1_valid3", bus.out_data_valid, 1'b1);
        tick();
        @(negedge clk);
        chk("t1_wr_after", bus.out_data_wr, 1'b0);
        chk("t1_hold", bus.out_data, W3);
        chk("t1_seq_after", bus.seq_num, 8'h01);
        chk("t1_cnt_after", bus.sent_cnt, 64'h1);

        // Backpressure: request held while out_ready is low
        tick();
        bus.out_ready = 1'b0;
        set_req(48'h1111_2222_3333, 1'b0, 32'hDEAD_BEEF, 48'h4444_5555_6666, 32'h10,
                48'h7);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            chk("t2_ready_low", bus.req_ready, 1'b0);
            chk("t2_no_wr", bus.out_data_wr, 1'b0);
        end
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t2_ready_high", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("t2_head_tag", bus.out_data[133:132], 2'b01);
        chk("t2_head_seq", bus.out_data[7:0], 8'h01);
        tick(); tick(); tick(); tick();

        // Back-to-back with req_valid held high
        set_req(48'hBEEF, 1'b1, 32'h5, 48'hCAFE, 32'h9, 48'h100);
        bus.req_valid = 1'b1;
        nheads = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 15) bus.req_valid = 1'b0;
            @(negedge clk);
            if (bus.out_data_wr && bus.out_data[133:132] == 2'b01) begin
                if (nheads < 3) begin
                    hc[nheads] = c;
                    hs[nheads] = bus.out_data[7:0];
                end
                nheads++;
            end
        end
        chk("t3_nheads", nheads, 3);
        chk("t3_head0_cycle", hc[0], 1);
        chk("t3_head1_cycle", hc[1], 6);
        chk("t3_head2_cycle", hc[2], 11);
        chk("t3_seq0", hs[0], 8'h02);
        chk("t3_seq1", hs[1], 8'h03);
        chk("t3_seq2", hs[2], 8'h04);
        tick();

        // Inputs changing after accept do not affect the packet
        set_req(48'h0102_0304_0506, 1'b1, 32'hA5A5_A5A5, 48'h0A0B_0C0D_0E0F, 32'h1234,
                48'h0000_0000_BEEF);
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        set_req(48'hFFFF_FFFF_FFFF, 1'b0, 32'h0, 48'h0, 32'hFFFF_FFFF, 48'hFFFF_FFFF_FFFF);
        @(negedge clk);
        chk("t5_dst", bus.out_data[127:80], 48'h0102_0304_0506);
        tick();
        @(negedge clk);
        chk("t5_ptime", bus.out_data[127:80], 48'h0000_0000_BEEF);
        chk("t5_period", bus.out_data[31:0], 32'h1234);
        chk("t5_dir", bus.out_data[79], 1'b1);
        tick();
        @(negedge clk);
        chk("t5_dmac", bus.out_data[127:80], 48'h0A0B_0C0D_0E0F);
        tick(); tick();

        // Reset mid-packet
        set_req(48'h77, 1'b1, 32'h1, 48'h88, 32'h2, 48'h3);
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_data", bus.out_data, 134'h0);
        chk("t6_rst_wr", bus.out_data_wr, 1'b0);
        chk("t6_rst_valid", bus.out_data_valid, 1'b0);
        chk("t6_rst_seq", bus.seq_num, 8'h00);
        chk("t6_rst_cnt", bus.sent_cnt, 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("t6_head_tag", bus.out_data[133:132], 2'b01);
        chk("t6_head_seq", bus.out_data[7:0], 8'h00);
        tick(); tick(); tick(); tick();
        @(negedge clk);
        chk("t6_cnt_after", bus.sent_cnt, 64'h1);
        chk("t6_seq_after", bus.seq_num, 8'h01);

        // 256 packets: sequence wraps
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.req_valid = 1'b1;
        nheads   = 0;
        last_seq = 8'h00;
        for (int c = 1; c <= 1280; c++) begin
            tick();
            if (c == 1280) bus.req_valid = 1'b0;
            @(negedge clk);
            if (bus.out_data_wr && bus.out_data[133:132] == 2'b01) begin
                last_seq = bus.out_data[7:0];
                nheads++;
            end
        end
        chk("t4_nheads", nheads, 256);
        chk("t4_last_seq", last_seq, 8'hFF);
        chk("t4_seq_wrap", bus.seq_num, 8'h00);
        chk("t4_sent_cnt", bus.sent_cnt, 64'd256);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
